// File: rtl/uart_tx_fifo_if.sv
// Host write port of the UART transmitter: byte strobe and data in, FIFO status out.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       empty;

  modport master (output wr_en, din, input full, empty);
  modport slave  (input wr_en, din, output full, empty);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (optional parity, 1 or 2 stop bits) driven by a 16x baud tick.
// Bytes are queued in a small FIFO and sent LSB first; queued frames follow each other with no idle gap.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          clken,
  uart_tx_fifo_if.slave host,
  output logic          tx,
  output logic          tx_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          full, empty;
  logic          wr_ok, pop;

  state_t        state, state_n;
  logic [3:0]    sample, sample_n;
  logic [2:0]    bitpos, bitpos_n;
  logic          stop_cnt, stop_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n, tx_busy_n;

  assign host.full  = full;
  assign host.empty = empty;
  assign wr_ok      = host.wr_en && !full;

  always_comb begin
    count_n = count;
    if (wr_ok && !pop) begin
      count_n = count + 1'b1;
    end else if (!wr_ok && pop) begin
      count_n = count - 1'b1;
    end
  end

  // Flags are registered from the next occupancy so they describe the count at the start of each cycle.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH_CNT);
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr_ok) mem[wr_ptr] <= host.din;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sample   <= '0;
      bitpos   <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      sample   <= sample_n;
      bitpos   <= bitpos_n;
      stop_cnt <= stop_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
      tx_busy  <= tx_busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    sample_n   = sample;
    bitpos_n   = bitpos;
    stop_cnt_n = stop_cnt;
    shift_n    = shift;
    tx_n       = tx;
    tx_busy_n  = tx_busy;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
        if (clken && !empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          tx_n      = 1'b0;
          sample_n  = 4'd0;
          tx_busy_n = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (clken) begin
          sample_n = sample + 4'd1;
          if (sample == 4'd15) begin
            tx_n     = shift[0];
            bitpos_n = 3'd0;
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (clken) begin
          sample_n = sample + 4'd1;
          if (sample == 4'd15) begin
            if (bitpos != 3'd7) begin
              bitpos_n = bitpos + 3'd1;
              tx_n     = shift[bitpos + 3'd1];
            end else if (PARITY_EN != 0) begin
              tx_n    = (^shift) ^ ODD;
              state_n = PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (clken) begin
          sample_n = sample + 4'd1;
          if (sample == 4'd15) begin
            tx_n       = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end
        end
      end
      STOP: begin
        // On the final stop tick a waiting byte starts immediately, keeping frames back to back.
        if (clken) begin
          sample_n = sample + 4'd1;
          if (sample == 4'd15) begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt_n = 1'b1;
            end else if (!empty) begin
              pop     = 1'b1;
              shift_n = mem[rd_ptr];
              tx_n    = 1'b0;
              state_n = START;
            end else begin
              tx_busy_n = 1'b0;
              state_n   = IDLE;
            end
          end
        end
      end
      default: begin
        state_n   = IDLE;
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three lanes (8N1, even parity, odd parity with two stop bits) share one write stream;
// a scoreboard of queued bytes feeds a tick-level frame monitor and a FIFO occupancy model.
module tb_uart_tx_fifo;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       clken;
  logic       wr_en;
  logic [7:0] din;
  logic [1:0] div = 2'd0;
  logic [2:0] tx_v, busy_v, full_v, empty_v;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [3][$];
  int         model_cnt [3];
  int         prev_cnt  [3];

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) div <= div + 2'd1;
  assign clken = (div == 2'd3);

  uart_tx_fifo_if bus0 ();
  uart_tx_fifo_if bus1 ();
  uart_tx_fifo_if bus2 ();
  assign bus0.wr_en = wr_en;
  assign bus0.din   = din;
  assign bus1.wr_en = wr_en;
  assign bus1.din   = din;
  assign bus2.wr_en = wr_en;
  assign bus2.din   = din;
  assign full_v  = {bus2.full, bus1.full, bus0.full};
  assign empty_v = {bus2.empty, bus1.empty, bus0.empty};

  uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .host(bus0.slave), .tx(tx_v[0]), .tx_busy(busy_v[0]));
  uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .host(bus1.slave), .tx(tx_v[1]), .tx_busy(busy_v[1]));
  uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .host(bus2.slave), .tx(tx_v[2]), .tx_busy(busy_v[2]));

  function automatic int lane_pen(input int g);
    return (g == 0) ? 0 : 1;
  endfunction

  function automatic int lane_odd(input int g);
    return (g == 2) ? 1 : 0;
  endfunction

  function automatic int lane_bits(input int g);
    return 10 + lane_pen(g) + ((g == 2) ? 2 : 1) - 1;
  endfunction

  // Line level of every bit slot: start 0, data LSB first, optional parity, then ones for stop/unused slots.
  function automatic logic [11:0] frame_pattern(input int g, input logic [7:0] b);
    logic [11:0] p;
    p      = '1;
    p[0]   = 1'b0;
    p[8:1] = b;
    if (lane_pen(g) == 1) p[9] = (^b) ^ (lane_odd(g) == 1);
    return p;
  endfunction

  task automatic check_output(input bit ok, input string name, input int lane,
                              input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("[TB] FAIL %s lane %0d: got 0x%0h, expected 0x%0h at %0t", name, lane, act, req, $time);
  endtask

  task automatic apply_stimulus(input logic en, input logic [7:0] b);
    @(negedge clk_50m);
    wr_en = en;
    din   = b;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (c < 8000 && !(model_cnt[0] == 0 && model_cnt[1] == 0 && model_cnt[2] == 0 && busy_v == 3'b000)) begin
      @(negedge clk_50m);
      c++;
    end
    check_output(c < 8000, name, 0, c, 8000);
    repeat (8) @(negedge clk_50m);
  endtask

  // Scoreboard push: a write is taken whenever the modelled occupancy at the start of the cycle is below 4.
  always @(posedge clk_50m or negedge rst_n) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        exp_q[g].delete();
        model_cnt[g] = 0;
        prev_cnt[g]  = 0;
      end else begin
        prev_cnt[g] = model_cnt[g];
        if (wr_en && model_cnt[g] < 4) begin
          exp_q[g].push_back(din);
          model_cnt[g]++;
        end
      end
    end
  end

  always @(negedge clk_50m) begin
    if (rst_n === 1'b1) begin
      for (int g = 0; g < 3; g++) begin
        check_output(full_v[g] == (model_cnt[g] == 4) && empty_v[g] == (model_cnt[g] == 0), "fifo_flags", g,
                     {full_v[g], empty_v[g]}, {model_cnt[g] == 4, model_cnt[g] == 0});
      end
    end
  end

  // Tick monitor: outside a frame a start bit is due exactly when bytes were waiting; inside a frame every tick is checked.
  logic [11:0] pat [3];
  logic [11:0] obs [3];
  logic [7:0]  cur [3];
  int          tick [3];
  int          bad [3];
  bit          in_frame [3];

  initial begin : monitor
    bit ce;
    bit exp_start;
    for (int g = 0; g < 3; g++) in_frame[g] = 1'b0;
    forever begin
      @(posedge clk_50m);
      ce = clken;
      #1;
      for (int g = 0; g < 3; g++) begin
        if (rst_n !== 1'b1) begin
          in_frame[g] = 1'b0;
        end else if (ce) begin
          if (!in_frame[g]) begin
            exp_start = (prev_cnt[g] > 0);
            check_output({busy_v[g], tx_v[g]} == (exp_start ? 2'b10 : 2'b01), "idle_tick", g,
                         {busy_v[g], tx_v[g]}, exp_start ? 2'b10 : 2'b01);
            if (exp_start && tx_v[g] == 1'b0 && exp_q[g].size() > 0) begin
              cur[g]      = exp_q[g].pop_front();
              model_cnt[g]--;
              pat[g]      = frame_pattern(g, cur[g]);
              obs[g]      = '1;
              tick[g]     = 0;
              bad[g]      = 0;
              in_frame[g] = 1'b1;
            end
          end
          if (in_frame[g]) begin
            if (tx_v[g] != pat[g][tick[g] / 16] || busy_v[g] != 1'b1) bad[g]++;
            if (tick[g] % 16 == 8) obs[g][tick[g] / 16] = tx_v[g];
            tick[g]++;
            if (tick[g] == lane_bits(g) * 16) begin
              check_output(bad[g] == 0 && obs[g] == pat[g], "frame", g, {bad[g][15:0], 4'h0, obs[g]}, {20'h0, pat[g]});
              in_frame[g] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] burst [5];
    int c;
    int lows;
    burst = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h99};
    rst_n = 1'b0;
    wr_en = 1'b0;
    din   = 8'h00;
    repeat (5) @(negedge clk_50m);
    #3 rst_n = 1'b1;
    @(negedge clk_50m);
    for (int g = 0; g < 3; g++)
      check_output({tx_v[g], busy_v[g], full_v[g], empty_v[g]} == 4'b1001, "reset_outputs", g,
                   {tx_v[g], busy_v[g], full_v[g], empty_v[g]}, 4'b1001);

    $display("[TB] single byte 0xA5");
    apply_stimulus(1'b1, 8'hA5);
    apply_stimulus(1'b0, 8'h00);
    wait_drain("drain_a5");

    $display("[TB] burst of five writes into an idle FIFO");
    do @(negedge clk_50m); while (!clken);
    wr_en = 1'b1;
    din   = burst[0];
    for (int i = 1; i < 5; i++) apply_stimulus(1'b1, burst[i]);
    apply_stimulus(1'b0, 8'h00);
    wait_drain("drain_burst");

    $display("[TB] parity byte 0x07");
    apply_stimulus(1'b1, 8'h07);
    apply_stimulus(1'b0, 8'h00);
    wait_drain("drain_parity");

    $display("[TB] random writes, then sustained writes against a full FIFO");
    for (int i = 0; i < 3000; i++) apply_stimulus($urandom_range(0, 15) == 0, 8'($urandom));
    for (int i = 0; i < 400; i++) apply_stimulus(1'b1, 8'($urandom));
    apply_stimulus(1'b0, 8'h00);
    wait_drain("drain_random");

    $display("[TB] reset during data bit 3 of 0x81");
    apply_stimulus(1'b1, 8'h81);
    apply_stimulus(1'b0, 8'h00);
    c = 0;
    while (c < 200 && tx_v[0] !== 1'b0) begin
      @(negedge clk_50m);
      c++;
    end
    check_output(c < 200, "start_0x81", 0, c, 200);
    repeat (280) @(negedge clk_50m);
    check_output(tx_v[0] == 1'b0 && busy_v[0] == 1'b1, "bit3_0x81", 0, {busy_v[0], tx_v[0]}, 2'b10);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      check_output({tx_v[g], busy_v[g], full_v[g], empty_v[g]} == 4'b1001, "async_reset", g,
                   {tx_v[g], busy_v[g], full_v[g], empty_v[g]}, 4'b1001);
    repeat (10) @(negedge clk_50m);
    #3 rst_n = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk_50m);
      if (tx_v != 3'b111 || busy_v != 3'b000) lows++;
    end
    check_output(lows == 0, "idle_after_reset", 0, lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
